// File: rtl/uart_wb_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_wb_sequencer : Wishbone master that programs an 8250 UART, then feeds
//                     a valid/ready byte stream into THR.      Rev 1.0
// ---------------------------------------------------------------------------
module uart_wb_sequencer #(
  parameter logic [31:0] UART_BASE   = 32'h1250_0000,
  parameter logic [15:0] DIVISOR     = 16'd27,
  parameter logic [7:0]  LCR_VAL     = 8'h03,
  parameter logic [7:0]  POLL_GAP    = 8'd4,
  parameter logic [7:0]  ACK_TIMEOUT = 8'd16
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  output logic [31:0] ADR_O,
  output logic [31:0] DAT_O,
  input  logic [31:0] DAT_I,
  output logic        WE_O,
  output logic [3:0]  SEL_O,
  output logic        STB_O,
  output logic        CYC_O,
  input  logic        ACK_I,
  input  logic        cfg_start,
  input  logic        tx_valid,
  input  logic [7:0]  tx_data,
  output logic        tx_ready,
  output logic        init_done,
  output logic        busy,
  output logic        err
);

  localparam logic [3:0] S_INIT0 = 4'd0;
  localparam logic [3:0] S_INIT1 = 4'd1;
  localparam logic [3:0] S_INIT2 = 4'd2;
  localparam logic [3:0] S_INIT3 = 4'd3;
  localparam logic [3:0] S_INIT4 = 4'd4;
  localparam logic [3:0] S_INIT5 = 4'd5;
  localparam logic [3:0] S_INIT6 = 4'd6;
  localparam logic [3:0] S_READY = 4'd7;
  localparam logic [3:0] S_POLL  = 4'd8;
  localparam logic [3:0] S_GAP   = 4'd9;
  localparam logic [3:0] S_WRITE = 4'd10;
  localparam logic [3:0] S_ERROR = 4'd11;

  logic [3:0]  state_q, state_d, tgt;
  logic        idle_q, idle_d, stb_q, stb_d, we_q, we_d;
  logic        err_q, err_d, done_q, done_d, pend_q, pend_d;
  logic [31:0] adr_q, adr_d;
  logic [7:0]  dat_q, dat_d, byte_q, byte_d, tmo_q, tmo_d, gap_q, gap_d;
  logic [2:0]  off;
  logic        launch, w_ack, w_cfg, w_rest, unused_dat;

  assign w_ack      = (ACK_I == 1'b1);
  assign w_rest     = (state_q == S_READY) || (state_q == S_ERROR);
  assign w_cfg      = cfg_start | pend_q;
  assign unused_dat = ^{DAT_I[31:6], DAT_I[4:0]};

  // idle_q marks the one bus-idle cycle spent in an access state before its
  // strobe is launched; every strobe starts through the launch block below.
  always_comb begin
    state_d = state_q;  idle_d = idle_q;  stb_d = stb_q;  we_d = we_q;
    adr_d   = adr_q;    dat_d  = dat_q;   tmo_d = tmo_q;  gap_d = gap_q;
    byte_d  = byte_q;   err_d  = err_q;   done_d = done_q;
    pend_d  = pend_q | (cfg_start & ~w_rest);
    launch  = 1'b0;     tgt    = state_q; off = 3'd0;
    case (state_q)
      S_READY: begin
        if (cfg_start) begin
          launch = 1'b1; tgt = S_INIT0; err_d = 1'b0; done_d = 1'b0; pend_d = 1'b0;
        end else if (tx_valid) begin
          launch = 1'b1; tgt = S_POLL; byte_d = tx_data;
        end
      end
      S_ERROR: begin
        if (w_cfg) begin
          launch = 1'b1; tgt = S_INIT0; err_d = 1'b0; done_d = 1'b0; pend_d = 1'b0;
        end
      end
      S_GAP: begin
        if (w_cfg) begin
          launch = 1'b1; tgt = S_INIT0; done_d = 1'b0; pend_d = 1'b0;
        end else if (gap_q + 8'd1 >= POLL_GAP) begin
          launch = 1'b1; tgt = S_POLL;
        end else begin
          gap_d = gap_q + 8'd1;
        end
      end
      default: begin
        if (stb_q) begin
          if (w_ack) begin
            stb_d = 1'b0; we_d = 1'b0; adr_d = 32'd0; dat_d = 8'd0;
            if (w_cfg) begin
              state_d = S_INIT0; idle_d = 1'b1; done_d = 1'b0; pend_d = 1'b0;
            end else begin
              case (state_q)
                S_INIT6: begin state_d = S_READY; done_d = 1'b1; end
                S_WRITE: state_d = S_READY;
                S_POLL: begin
                  if (DAT_I[5]) begin
                    state_d = S_WRITE; idle_d = 1'b1;
                  end else begin
                    state_d = S_GAP; gap_d = 8'd0;
                  end
                end
                default: begin state_d = state_q + 4'd1; idle_d = 1'b1; end
              endcase
            end
          end else if (tmo_q + 8'd1 >= ACK_TIMEOUT) begin
            stb_d = 1'b0; we_d = 1'b0; adr_d = 32'd0; dat_d = 8'd0;
            state_d = S_ERROR; err_d = 1'b1; done_d = 1'b0;
          end else begin
            tmo_d = tmo_q + 8'd1;
          end
        end else begin
          // Idle slot over (or an unreachable encoding): launch, honouring restarts.
          launch = 1'b1;
          if (w_cfg || !idle_q || state_q > S_ERROR) begin
            tgt = S_INIT0; pend_d = 1'b0; done_d = 1'b0;
            if (cfg_start || pend_q) err_d = 1'b0;
          end
        end
      end
    endcase

    if (launch) begin
      state_d = tgt; idle_d = 1'b0; stb_d = 1'b1; we_d = 1'b1; tmo_d = 8'd0; dat_d = 8'd0;
      case (tgt)
        S_INIT0: begin off = 3'd3; dat_d = 8'h83; end
        S_INIT1: begin off = 3'd0; dat_d = DIVISOR[7:0]; end
        S_INIT2: begin off = 3'd1; dat_d = DIVISOR[15:8]; end
        S_INIT3: begin off = 3'd3; dat_d = LCR_VAL & 8'h7F; end
        S_INIT4: begin off = 3'd2; dat_d = 8'h06; end
        S_INIT5: begin off = 3'd2; dat_d = 8'h00; end
        S_INIT6: begin off = 3'd1; dat_d = 8'h00; end
        S_POLL:  begin off = 3'd5; we_d = 1'b0; end
        S_WRITE: begin off = 3'd0; dat_d = byte_q; end
        default: off = 3'd0;
      endcase
      adr_d = UART_BASE + {29'd0, off};
    end
  end

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      state_q <= S_INIT0; idle_q <= 1'b1; stb_q <= 1'b0; we_q <= 1'b0;
      adr_q   <= 32'd0;   dat_q  <= 8'd0; tmo_q <= 8'd0; gap_q <= 8'd0;
      byte_q  <= 8'd0;    err_q  <= 1'b0; done_q <= 1'b0; pend_q <= 1'b0;
    end else begin
      state_q <= state_d; idle_q <= idle_d; stb_q <= stb_d; we_q <= we_d;
      adr_q   <= adr_d;   dat_q  <= dat_d;  tmo_q <= tmo_d; gap_q <= gap_d;
      byte_q  <= byte_d;  err_q  <= err_d;  done_q <= done_d; pend_q <= pend_d;
    end
  end

  assign ADR_O     = adr_q;
  assign DAT_O     = {24'd0, dat_q};
  assign WE_O      = we_q;
  assign SEL_O     = {3'b000, stb_q};
  assign STB_O     = stb_q;
  assign CYC_O     = stb_q;
  assign tx_ready  = (state_q == S_READY);
  assign busy      = ~w_rest;
  assign err       = err_q;
  assign init_done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_wb_sequencer.sv
`default_nettype none
// tb_uart_wb_sequencer : directed bench with a one-cycle-ack UART slave model.
module tb_uart_wb_sequencer;
  localparam logic [31:0] BASE = 32'h1250_0000;

  logic        CLK_I = 1'b0;
  logic        RST_I = 1'b0;
  logic [31:0] ADR_O, DAT_O;
  logic [31:0] DAT_I = 32'd0;
  logic        WE_O, STB_O, CYC_O;
  logic [3:0]  SEL_O;
  logic        ACK_I = 1'b0;
  logic        cfg_start, tx_valid, tx_ready, init_done, busy, err;
  logic [7:0]  tx_data;

  int ntests = 0, nfail = 0;
  int cyc = 0, nlog = 0, nreads = 0, rd_base = 0, run = 0, last_run = 0;
  int rd_idx, base, k, lows;
  logic        stall_init2;
  logic [7:0]  lsr_vals [8];
  logic [7:0]  lsr_dflt;
  logic [31:0] l_adr [256];
  logic [7:0]  l_dat [256];
  logic        l_we  [256];
  int          l_cyc [256];
  logic [2:0]  exp_off [7] = '{3'd3, 3'd0, 3'd1, 3'd3, 3'd2, 3'd2, 3'd1};
  logic [7:0]  exp_dat [7] = '{8'h83, 8'h02, 8'h01, 8'h03, 8'h06, 8'h00, 8'h00};

  uart_wb_sequencer #(
    .UART_BASE(BASE), .DIVISOR(16'h0102), .LCR_VAL(8'h03),
    .POLL_GAP(8'd4), .ACK_TIMEOUT(8'd16)
  ) dut (
    .CLK_I(CLK_I), .RST_I(RST_I), .ADR_O(ADR_O), .DAT_O(DAT_O), .DAT_I(DAT_I),
    .WE_O(WE_O), .SEL_O(SEL_O), .STB_O(STB_O), .CYC_O(CYC_O), .ACK_I(ACK_I),
    .cfg_start(cfg_start), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .init_done(init_done), .busy(busy), .err(err)
  );

  always #5 CLK_I = ~CLK_I;

  assign rd_idx = nreads - rd_base;

  // UART slave: acks one cycle after strobe, answers LSR reads from a table,
  // and logs every completed access with the cycle of its ack edge.
  always @(posedge CLK_I) begin
    cyc <= cyc + 1;
    if (STB_O && !ACK_I && !(stall_init2 && WE_O && ADR_O == BASE + 32'd1 && DAT_O[7:0] == 8'h01)) begin
      ACK_I <= 1'b1;
      if (!WE_O) begin
        DAT_I  <= {24'd0, (rd_idx >= 0 && rd_idx < 8) ? lsr_vals[rd_idx[2:0]] : lsr_dflt};
        nreads <= nreads + 1;
      end
    end else begin
      ACK_I <= 1'b0;
    end
    if (STB_O && ACK_I === 1'b1) begin
      l_adr[nlog] <= ADR_O; l_dat[nlog] <= DAT_O[7:0]; l_we[nlog] <= WE_O; l_cyc[nlog] <= cyc;
      nlog <= nlog + 1;
    end
    if (STB_O) run <= run + 1;
    else if (run != 0) begin last_run <= run; run <= 0; end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK_I);
    #1;
  endtask

  task automatic wait_log(input int n, input int budget, input string tag);
    int c = 0;
    while (nlog < n && c < budget) begin tick(1); c++; end
    check1(tag, nlog >= n, 1'b1);
  endtask

  task automatic check_init(input int b, input string tag);
    for (int i = 0; i < 7; i++) begin
      check1($sformatf("%s_we%0d", tag, i), l_we[b+i], 1'b1);
      check($sformatf("%s_adr%0d", tag, i), l_adr[b+i], BASE + {29'd0, exp_off[i]});
      check($sformatf("%s_dat%0d", tag, i), {24'd0, l_dat[b+i]}, {24'd0, exp_dat[i]});
      if (i > 0) check($sformatf("%s_gap%0d", tag, i), l_cyc[b+i] - l_cyc[b+i-1], 32'd3);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tx_valid = 1'b0; tx_data = 8'h00; cfg_start = 1'b0; stall_init2 = 1'b0; lsr_dflt = 8'h20;
    for (int i = 0; i < 8; i++) lsr_vals[i] = 8'h20;
    #3;
    check1("rst_stb", STB_O, 1'b0);   check1("rst_cyc", CYC_O, 1'b0);
    check1("rst_we", WE_O, 1'b0);     check("rst_adr", ADR_O, 32'd0);
    check("rst_dat", DAT_O, 32'd0);   check("rst_sel", {28'd0, SEL_O}, 32'd0);
    check1("rst_txrdy", tx_ready, 1'b0); check1("rst_done", init_done, 1'b0);
    check1("rst_busy", busy, 1'b1);   check1("rst_err", err, 1'b0);
    @(posedge CLK_I); @(negedge CLK_I); RST_I = 1'b1;

    // Power-on init sequence
    base = nlog;
    wait_log(base + 7, 80, "init_wait");
    check_init(base, "init");
    check1("init_done", init_done, 1'b1); check1("init_txrdy", tx_ready, 1'b1);
    check1("init_busy", busy, 1'b0);      check("init_sel_idle", {28'd0, SEL_O}, 32'd0);

    // Single byte, THR already empty
    rd_base = nreads; lsr_vals[0] = 8'h20; base = nlog;
    tx_data = 8'h41; tx_valid = 1'b1;
    check1("tx_rdy_hi", tx_ready, 1'b1);
    tick(1); tx_valid = 1'b0;
    check("tx_sel", {28'd0, SEL_O}, 32'd1);
    lows = 0; k = 0;
    while (tx_ready !== 1'b1 && k < 20) begin lows++; tick(1); k++; end
    check("tx_low_cycles", lows, 32'd5);
    check("tx_nacc", nlog - base, 32'd2);
    check1("tx_rd_we", l_we[base], 1'b0);   check("tx_rd_adr", l_adr[base], BASE + 32'd5);
    check1("tx_wr_we", l_we[base+1], 1'b1); check("tx_wr_adr", l_adr[base+1], BASE);
    check("tx_wr_dat", {24'd0, l_dat[base+1]}, 32'h41);
    check("tx_rd_wr_gap", l_cyc[base+1] - l_cyc[base], 32'd3);

    // THR busy twice, then empty
    rd_base = nreads; lsr_vals[0] = 8'h00; lsr_vals[1] = 8'h00; lsr_vals[2] = 8'h20; base = nlog;
    tx_data = 8'h5A; tx_valid = 1'b1; tick(1); tx_valid = 1'b0;
    wait_log(base + 4, 60, "poll_wait");
    for (int i = 0; i < 3; i++) begin
      check1($sformatf("poll_we%0d", i), l_we[base+i], 1'b0);
      check($sformatf("poll_adr%0d", i), l_adr[base+i], BASE + 32'd5);
    end
    check("poll_gap1", l_cyc[base+1] - l_cyc[base], 32'd6);
    check("poll_gap2", l_cyc[base+2] - l_cyc[base+1], 32'd6);
    check("poll_wr_gap", l_cyc[base+3] - l_cyc[base+2], 32'd3);
    check1("poll_wr_we", l_we[base+3], 1'b1);
    check("poll_wr_dat", {24'd0, l_dat[base+3]}, 32'h5A);
    check1("poll_txrdy", tx_ready, 1'b1);

    // cfg_start beats tx_valid; slave stalls on INIT_2 -> timeout
    stall_init2 = 1'b1; base = nlog;
    cfg_start = 1'b1; tx_valid = 1'b1; tx_data = 8'hEE;
    check1("cfg_txrdy_same", tx_ready, 1'b1);
    tick(1); cfg_start = 1'b0; tx_valid = 1'b0;
    check1("cfg_busy", busy, 1'b1); check1("cfg_done_clr", init_done, 1'b0);
    k = 0;
    while (err !== 1'b1 && k < 100) begin tick(1); k++; end
    check1("tmo_err", err, 1'b1);     check1("tmo_busy", busy, 1'b0);
    check1("tmo_txrdy", tx_ready, 1'b0); check1("tmo_stb", STB_O, 1'b0);
    check1("tmo_cyc", CYC_O, 1'b0);   check1("tmo_done", init_done, 1'b0);
    tick(1);
    check("tmo_len", last_run, 32'd16);
    check("tmo_nacc", nlog - base, 32'd2);
    check("tmo_last_adr", l_adr[base+1], BASE);
    check("tmo_last_dat", {24'd0, l_dat[base+1]}, 32'h02);
    stall_init2 = 1'b0; tick(3);
    check1("tmo_err_sticky", err, 1'b1); check1("tmo_bus_idle", STB_O, 1'b0);
    base = nlog; cfg_start = 1'b1; tick(1); cfg_start = 1'b0;
    check1("rec_err_clr", err, 1'b0); check1("rec_stb", STB_O, 1'b1);
    check("rec_adr", ADR_O, BASE + 32'd3);
    wait_log(base + 7, 80, "rec_wait");
    check_init(base, "rec");
    check1("rec_done", init_done, 1'b1);

    // cfg_start during a poll access
    rd_base = nreads; for (int i = 0; i < 8; i++) lsr_vals[i] = 8'h00; lsr_dflt = 8'h00;
    base = nlog; tx_data = 8'h77; tx_valid = 1'b1; tick(1); tx_valid = 1'b0;
    check1("pc_stb", STB_O, 1'b1); check1("pc_rd", WE_O, 1'b0);
    cfg_start = 1'b1; tick(1); cfg_start = 1'b0;
    wait_log(base + 8, 100, "pc_wait");
    check1("pc_rd_we", l_we[base], 1'b0); check("pc_rd_adr", l_adr[base], BASE + 32'd5);
    check("pc_restart_gap", l_cyc[base+1] - l_cyc[base], 32'd3);
    check_init(base + 1, "pc");
    tick(10);
    check("pc_no_thr", nlog - base, 32'd8);
    check1("pc_txrdy", tx_ready, 1'b1); check1("pc_done", init_done, 1'b1);

    // Asynchronous reset in the middle of a THR write
    rd_base = nreads; lsr_dflt = 8'h20; for (int i = 0; i < 8; i++) lsr_vals[i] = 8'h20;
    tx_data = 8'h33; tx_valid = 1'b1; tick(1); tx_valid = 1'b0;
    k = 0;
    while (!(STB_O && WE_O) && k < 20) begin tick(1); k++; end
    check1("ar_wr_seen", STB_O && WE_O, 1'b1);
    #2 RST_I = 1'b0;
    #1;
    check1("ar_stb", STB_O, 1'b0); check1("ar_cyc", CYC_O, 1'b0);
    check1("ar_we", WE_O, 1'b0);   check("ar_adr", ADR_O, 32'd0);
    check1("ar_busy", busy, 1'b1);
    base = nlog;
    @(negedge CLK_I); RST_I = 1'b1;
    wait_log(base + 7, 80, "ar_wait");
    check_init(base, "ar");
    check1("ar_done", init_done, 1'b1);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
`default_nettype wire
